// File: rtl/trg_pkg.sv
// Shared types and constants for the per-channel trigger pulse generator.
package trg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_PULSE,
        ST_HOLDOFF
    } trg_state_t;

    localparam int unsigned TRG_NCH    = 8;
    localparam int unsigned DROP_CNT_W = 16;

    // Counter must hold the largest reload value; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned d,
                                              input int unsigned p,
                                              input int unsigned h);
        int unsigned m;
        int unsigned w;
        m = d;
        if (p > m) m = p;
        if (h > m) m = h;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/trg_pulse_chan.sv
// One trigger channel: IDLE -> DELAY -> PULSE -> HOLDOFF sequencer with a shared down-counter.
module trg_pulse_chan
    import trg_pkg::*;
#(
    parameter int unsigned DELAY   = 2,
    parameter int unsigned PULSE_W = 3,
    parameter int unsigned HOLDOFF = 1,
    parameter int unsigned CW      = cnt_width(DELAY, PULSE_W, HOLDOFF)
) (
    input  logic clk,
    input  logic rst,
    input  logic edge_i,
    input  logic en_i,
    output logic pulse_o,
    output logic busy_o,
    output logic drop_o
);

    localparam logic [CW-1:0] DLY_LD = CW'((DELAY   == 0) ? 0 : DELAY - 1);
    localparam logic [CW-1:0] PLS_LD = CW'((PULSE_W == 0) ? 0 : PULSE_W - 1);
    localparam logic [CW-1:0] HLD_LD = CW'((HOLDOFF == 0) ? 0 : HOLDOFF - 1);

    trg_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    assign accept = edge_i & en_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (DELAY == 0) begin
                        state_d = ST_PULSE;
                        cnt_d   = PLS_LD;
                    end else begin
                        state_d = ST_DELAY;
                        cnt_d   = DLY_LD;
                    end
                end
            end
            ST_DELAY: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PLS_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = HLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs come from registered state only; acceptance needs a registered IDLE.
    assign pulse_o = (state_q == ST_PULSE);
    assign busy_o  = (state_q != ST_IDLE);
    assign drop_o  = accept & (state_q != ST_IDLE);

endmodule

// File: rtl/trg_pulse_gen.sv
// NCH independent trigger pulse channels fed by rising edges of trg.
// Define TRG_DROP_CNT_EN to add the saturating drop_cnt counter and its drop_clr input.
module trg_pulse_gen
    import trg_pkg::*;
#(
    parameter int unsigned NCH     = TRG_NCH,
    parameter int unsigned DELAY   = 2,
    parameter int unsigned PULSE_W = 3,
    parameter int unsigned HOLDOFF = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NCH-1:0]        trg,
`ifdef TRG_DROP_CNT_EN
    input  logic                  drop_clr,
    output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
    output logic [NCH-1:0]        pulse_out,
    output logic [NCH-1:0]        busy
);

    logic [NCH-1:0] trg_q;
    logic [NCH-1:0] edge_w;
    logic [NCH-1:0] drop_w;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trg_q <= '0;
        end else begin
            trg_q <= trg;
        end
    end

    assign edge_w = trg & ~trg_q;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        trg_pulse_chan #(
            .DELAY  (DELAY),
            .PULSE_W(PULSE_W),
            .HOLDOFF(HOLDOFF)
        ) u_chan (
            .clk    (clk),
            .rst    (rst),
            .edge_i (edge_w[i]),
            .en_i   (en),
            .pulse_o(pulse_out[i]),
            .busy_o (busy[i]),
            .drop_o (drop_w[i])
        );
    end

`ifdef TRG_DROP_CNT_EN
    localparam int unsigned SUM_W = DROP_CNT_W + 1;

    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [SUM_W-1:0]      drop_sum;

    always_comb begin
        drop_sum = {1'b0, drop_cnt_q} + SUM_W'($countones(drop_w));
        if (drop_clr) begin
            drop_cnt_d = '0;
        end else if (drop_sum[DROP_CNT_W]) begin
            drop_cnt_d = '1;
        end else begin
            drop_cnt_d = drop_sum[DROP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop;
    assign unused_drop = |drop_w;
`endif

endmodule

// File: tb/tb_trg_pulse_gen.sv
// Directed scoreboard bench for trg_pulse_gen at default parameters (DELAY=2, PULSE_W=3, HOLDOFF=1).
module tb_trg_pulse_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] trg;
    logic [7:0] pulse_out;
    logic [7:0] busy;
`ifdef TRG_DROP_CNT_EN
    logic        drop_clr;
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    trg_pulse_gen dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .trg      (trg),
`ifdef TRG_DROP_CNT_EN
        .drop_clr (drop_clr),
        .drop_cnt (drop_cnt),
`endif
        .pulse_out(pulse_out),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected {pulse_out, busy} k cycles into a scenario for one edge accepted at edge a:
    // busy after a..a+5, pulse after a+2..a+4.
    function automatic logic [15:0] pat(input int k, input int a, input logic [7:0] mask);
        logic [7:0] p;
        logic [7:0] b;
        b = (k >= a && k <= a + 5) ? mask : 8'h00;
        p = (k >= a + 2 && k <= a + 4) ? mask : 8'h00;
        return {p, b};
    endfunction

    task automatic step(input logic [7:0] t, input logic e, input logic [15:0] expv, input string tag);
        trg = t;
        en  = e;
        exp_q.push_back(expv);
        @(posedge clk);
        #1;
        chk(tag, {16'h0, pulse_out, busy}, {16'h0, exp_q.pop_front()});
    endtask

    task automatic chk_drops(input string tag, input logic [15:0] expv);
`ifdef TRG_DROP_CNT_EN
        chk(tag, {16'h0, drop_cnt}, {16'h0, expv});
`endif
    endtask

    task automatic do_reset(input logic [7:0] hold_trg);
        rst = 1'b1;
        trg = hold_trg;
        en  = 1'b1;
`ifdef TRG_DROP_CNT_EN
        drop_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out", {16'h0, pulse_out, busy}, 32'h0);
        chk_drops("reset_drop", 16'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Single edge on channel 0
        do_reset(8'h00);
        for (int k = 0; k <= 8; k++)
            step((k == 0) ? 8'h01 : 8'h00, 1'b1, pat(k, 0, 8'h01), $sformatf("single_k%0d", k));
        chk_drops("single_drop", 16'd0);

        // Second edge at E3 is dropped while the channel is busy
        do_reset(8'h00);
        for (int k = 0; k <= 8; k++)
            step((k == 0 || k == 3) ? 8'h01 : 8'h00, 1'b1, pat(k, 0, 8'h01), $sformatf("drop_k%0d", k));
        chk_drops("drop_cnt1", 16'd1);

        // Re-arm boundary: E5 and E6 (HOLDOFF->IDLE edge) dropped, E7 accepted
        for (int s = 5; s <= 7; s++) begin
            do_reset(8'h00);
            for (int k = 0; k <= 14; k++)
                step((k == 0 || k == s) ? 8'h01 : 8'h00, 1'b1,
                     (s == 7) ? (pat(k, 0, 8'h01) | pat(k, 7, 8'h01)) : pat(k, 0, 8'h01),
                     $sformatf("rearm_s%0d_k%0d", s, k));
            chk_drops($sformatf("rearm_s%0d_drop", s), (s == 7) ? 16'd0 : 16'd1);
        end

        // All channels together; re-edge at E2 drops on all eight
        do_reset(8'h00);
        for (int k = 0; k <= 8; k++)
            step((k == 0 || k == 2) ? 8'hFF : 8'h00, 1'b1, pat(k, 0, 8'hFF), $sformatf("par_k%0d", k));
        chk_drops("par_drop8", 16'd8);

        // en=0: edges ignored (not dropped), running channel 0 completes
        do_reset(8'h00);
        for (int k = 0; k <= 9; k++)
            step((k == 0) ? 8'h01 : (k >= 2 ? 8'hF1 : 8'h00), (k < 2), pat(k, 0, 8'h01),
                 $sformatf("en0_k%0d", k));
        chk_drops("en0_drop", 16'd0);

        // Async reset during PULSE, trg held high through release
        do_reset(8'h00);
        for (int k = 0; k <= 3; k++)
            step((k == 0 || k >= 2) ? 8'h01 : 8'h00, 1'b1, pat(k, 0, 8'h01), $sformatf("mid_k%0d", k));
        chk_drops("mid_drop_pre", 16'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_async_out", {16'h0, pulse_out, busy}, 32'h0);
        chk_drops("mid_async_drop", 16'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k <= 8; k++)
            step(8'h01, 1'b1, pat(k, 0, 8'h01), $sformatf("rel_k%0d", k));

`ifdef TRG_DROP_CNT_EN
        // Saturation, then clear racing a drop
        do_reset(8'h00);
        for (int i = 0; i < 25000; i++) begin
            trg = i[0] ? 8'h00 : 8'hFF;
            @(posedge clk);
            #1;
        end
        chk("sat_ffff", {16'h0, drop_cnt}, 32'h0000_FFFF);
        trg = 8'h00;
        repeat (10) @(posedge clk);
        #1;
        chk("sat_hold", {16'h0, drop_cnt}, 32'h0000_FFFF);
        trg = 8'hFF; @(posedge clk); #1;
        trg = 8'h00; @(posedge clk); #1;
        trg = 8'hFF; drop_clr = 1'b1; @(posedge clk); #1;
        chk("clr_vs_drop", {16'h0, drop_cnt}, 32'h0);
        drop_clr = 1'b0;
        trg = 8'h00; @(posedge clk); #1;
        trg = 8'hFF; @(posedge clk); #1;
        chk("after_clr_drop8", {16'h0, drop_cnt}, 32'd8);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
